// File: rtl/serial_crc8_engine.sv
// Bit-serial CRC-8 generator: MSB-first bits in over a valid/ready handshake,
// final CRC out over a valid/ready handshake and held until accepted.
module serial_crc8_engine #(
  parameter logic [7:0]  POLY       = 8'h07,
  parameter logic [7:0]  INIT       = 8'h00,
  parameter logic [7:0]  XOROUT     = 8'h00,
  parameter int unsigned FRAME_BITS = 8,
  localparam int unsigned CW        = $clog2(FRAME_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic [7:0]    crc_out,
  output logic          crc_valid,
  input  logic          crc_ready,
  output logic          busy,
  output logic [CW-1:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);

  state_t        state_q, state_d;
  logic [7:0]    crc_reg_q, crc_reg_d;
  logic [7:0]    crc_out_q, crc_out_d;
  logic          crc_valid_q, crc_valid_d;
  logic [CW-1:0] bit_count_q, bit_count_d;

  logic          fb;
  logic [7:0]    crc_next;

  // Single feedback tap: one XOR of the register MSB with the incoming bit,
  // then POLY selects which shifted positions take the feedback.
  assign fb       = crc_reg_q[7] ^ bit_in;
  assign crc_next = {crc_reg_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

  always_comb begin
    state_d     = state_q;
    crc_reg_d   = crc_reg_q;
    crc_out_d   = crc_out_q;
    crc_valid_d = crc_valid_q;
    bit_count_d = bit_count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SHIFT;
          crc_reg_d   = INIT;
          bit_count_d = '0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          crc_reg_d   = crc_next;
          bit_count_d = bit_count_q + CW'(1);
          if (bit_count_q == LAST_IDX) begin
            crc_out_d   = crc_next ^ XOROUT;
            crc_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (crc_ready) begin
          crc_valid_d = 1'b0;
          bit_count_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_reg_q   <= INIT;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      crc_reg_q   <= crc_reg_d;
      crc_out_q   <= crc_out_d;
      crc_valid_q <= crc_valid_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_ready = (state_q == SHIFT);
  assign busy      = (state_q != IDLE);
  assign crc_out   = crc_out_q;
  assign crc_valid = crc_valid_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_serial_crc8_engine.sv
// Scoreboard bench for serial_crc8_engine: three parameterisations (default,
// 72-bit frames, XOROUT=FF) sharing one clock and reset.
module tb_serial_crc8_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [3];
  logic       bit_in    [3];
  logic       bit_valid [3];
  logic       crc_ready [3];
  logic       bit_ready [3];
  logic       busy      [3];
  logic       crc_valid [3];
  logic [7:0] crc_out   [3];
  logic [7:0] bcnt      [3];
  logic [3:0] bc0;
  logic [6:0] bc1;
  logic [3:0] bc2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         k;
    logic [7:0] crc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_crc8_engine u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .bit_in(bit_in[0]),
    .bit_valid(bit_valid[0]), .bit_ready(bit_ready[0]), .crc_out(crc_out[0]),
    .crc_valid(crc_valid[0]), .crc_ready(crc_ready[0]), .busy(busy[0]),
    .bit_count(bc0)
  );

  serial_crc8_engine #(.FRAME_BITS(72)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .bit_in(bit_in[1]),
    .bit_valid(bit_valid[1]), .bit_ready(bit_ready[1]), .crc_out(crc_out[1]),
    .crc_valid(crc_valid[1]), .crc_ready(crc_ready[1]), .busy(busy[1]),
    .bit_count(bc1)
  );

  serial_crc8_engine #(.XOROUT(8'hFF)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .bit_in(bit_in[2]),
    .bit_valid(bit_valid[2]), .bit_ready(bit_ready[2]), .crc_out(crc_out[2]),
    .crc_valid(crc_valid[2]), .crc_ready(crc_ready[2]), .busy(busy[2]),
    .bit_count(bc2)
  );

  assign bcnt[0] = 8'(bc0);
  assign bcnt[1] = 8'(bc1);
  assign bcnt[2] = 8'(bc2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input int k);
    check("rst_crc_valid", 32'(crc_valid[k]), 0);
    check("rst_crc_out",   32'(crc_out[k]),   0);
    check("rst_bit_ready", 32'(bit_ready[k]), 0);
    check("rst_busy",      32'(busy[k]),      0);
    check("rst_bit_count", 32'(bcnt[k]),      0);
  endtask

  task automatic start_frame(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    check("start_busy",  32'(busy[k]),      1);
    check("start_ready", 32'(bit_ready[k]), 1);
    check("start_count", 32'(bcnt[k]),      0);
  endtask

  // Drives data[nbits-1:0] MSB-first; with rnd, bit_valid is randomised and
  // bit_count is checked to move only on accepted cycles.
  task automatic send_bits(input int k, input logic [79:0] data, input int nbits, input bit rnd);
    for (int i = nbits - 1; i >= 0; i--) begin
      bit accepted = 1'b0;
      int tries = 0;
      while (!accepted) begin
        logic v;
        logic [7:0] prev;
        v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bit_in[k]    = data[i];
        bit_valid[k] = v;
        prev = bcnt[k];
        tick();
        tries++;
        if (v) accepted = 1'b1;
        if (rnd) check("bc_step", 32'(bcnt[k]), v ? 32'(prev) + 1 : 32'(prev));
        if (!accepted && tries > 200) begin
          check("bit_accept_timeout", 0, 1);
          accepted = 1'b1;
        end
      end
    end
    bit_valid[k] = 1'b0;
    bit_in[k]    = 1'b0;
  endtask

  task automatic collect(input int k, input int nbits);
    exp_t e;
    int c = 0;
    while (!crc_valid[k] && c < 20) begin
      tick();
      c++;
    end
    if (!crc_valid[k]) begin
      check("crc_valid_timeout", 0, 1);
    end else if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      check("sb_inst", 32'(k), 32'(e.k));
      check("crc_out", 32'(crc_out[k]), 32'(e.crc));
      check("hold_count", 32'(bcnt[k]), 32'(nbits));
      check("hold_ready", 32'(bit_ready[k]), 0);
    end
  endtask

  task automatic release_result(input int k);
    crc_ready[k] = 1'b1;
    tick();
    crc_ready[k] = 1'b0;
    check("rel_valid", 32'(crc_valid[k]), 0);
    check("rel_busy",  32'(busy[k]),      0);
    check("rel_count", 32'(bcnt[k]),      0);
  endtask

  task automatic run_frame(input int k, input logic [79:0] data, input int nbits,
                           input logic [7:0] exp, input bit rnd);
    exp_t e;
    e.k = k;
    e.crc = exp;
    sb.push_back(e);
    start_frame(k);
    send_bits(k, data, nbits, rnd);
    check("latency", 32'(crc_valid[k]), 1);
    collect(k, nbits);
    release_result(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] held;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; bit_in[k] = 1'b0; bit_valid[k] = 1'b0; crc_ready[k] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_vals(0);
    check_reset_vals(1);

    run_frame(0, 80'h01, 8, 8'h07, 1'b0);
    run_frame(0, 80'h80, 8, 8'h89, 1'b0);
    run_frame(0, 80'hFF, 8, 8'hF3, 1'b0);

    run_frame(1, 80'h313233343536373839, 72, 8'hF4, 1'b0);
    run_frame(1, 80'h313233343536373839, 72, 8'hF4, 1'b1);

    // HOLD stalls, start ignored in HOLD and on the HOLD-exit cycle
    e.k = 0; e.crc = 8'h07; sb.push_back(e);
    start_frame(0);
    send_bits(0, 80'h01, 8, 1'b0);
    collect(0, 8);
    held = crc_out[0];
    for (int c = 0; c < 5; c++) begin
      start[0] = (c == 2);
      tick();
      check("stall_valid", 32'(crc_valid[0]), 1);
      check("stall_out",   32'(crc_out[0]),   32'(held));
      check("stall_ready", 32'(bit_ready[0]), 0);
      check("stall_busy",  32'(busy[0]),      1);
    end
    start[0] = 1'b1;
    crc_ready[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    crc_ready[0] = 1'b0;
    check("exit_busy",  32'(busy[0]),      0);
    check("exit_valid", 32'(crc_valid[0]), 0);
    check("exit_out",   32'(crc_out[0]),   8'h07);
    tick();
    check("no_queue_busy", 32'(busy[0]), 0);
    e.k = 0; e.crc = 8'h00; sb.push_back(e);
    start_frame(0);
    send_bits(0, 80'h00, 8, 1'b0);
    collect(0, 8);
    release_result(0);

    // reset after 4 of 8 bits
    start_frame(0);
    send_bits(0, 80'h0, 4, 1'b0);
    check("mid_count", 32'(bcnt[0]), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals(0);
    bit_valid[0] = 1'b1;
    bit_in[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("post_rst_valid", 32'(crc_valid[0]), 0);
      check("post_rst_busy",  32'(busy[0]),      0);
    end
    bit_valid[0] = 1'b0;
    bit_in[0] = 1'b0;
    run_frame(0, 80'h01, 8, 8'h07, 1'b0);

    run_frame(2, 80'h00, 8, 8'hFF, 1'b0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_crc8_engine.md
Name: serial_crc8_engine

Overview:
- Bit-serial CRC-8 generator that consumes a frame of single bits and produces its 8-bit CRC.
- Built from XOR feedback taps, with the XOR primitive from the gate library as the intended tap element. It is the downstream consumer of that cell.
- Sits between a serial bit source and a frame transmitter/checker.
- Input side uses a valid/ready bit handshake; output side uses a valid/ready result handshake.

Parameters:
- POLY, 8'h07, generator polynomial without the implicit x^8 term.
- INIT, 8'h00, CRC register value loaded at frame start.
- XOROUT, 8'h00, value XORed into the final CRC before presentation.
- FRAME_BITS, 8, data bits per frame. Must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a new frame. Honoured only in IDLE.
- bit_in  input  1  serial data bit, MSB-first.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  engine accepts a bit this cycle.
- crc_out  output  8  final CRC. Stable while crc_valid=1.
- crc_valid  output  1  crc_out is valid.
- crc_ready  input  1  consumer accepts crc_out.
- busy  output  1  high in SHIFT and HOLD.
- bit_count  output  CW  bits accepted in the current frame. CW = $clog2(FRAME_BITS+1).

Behaviour:
- Reset (synchronous, active-high, checked every rising clk edge, overrides all else):
  - state=IDLE, crc_reg=INIT, crc_out=0, crc_valid=0, bit_ready=0, busy=0, bit_count=0.
- IDLE:
  - bit_ready=0, busy=0.
  - start=1 -> next cycle: state=SHIFT, crc_reg=INIT, bit_count=0.
- SHIFT:
  - bit_ready=1, busy=1.
  - A bit is accepted on an edge where bit_valid & bit_ready.
  - On acceptance: fb = crc_reg[7] ^ bit_in; crc_reg <= {crc_reg[6:0],1'b0} ^ (fb ? POLY : 8'h00); bit_count++.
  - bit_valid=0 -> all state held. No timeout.
  - When the accepted bit is number FRAME_BITS (bit_count was FRAME_BITS-1): same edge sets crc_out = next_crc ^ XOROUT, crc_valid=1, state=HOLD.
  - The result is therefore visible in the cycle immediately after the last bit is accepted (1-cycle latency).
- HOLD:
  - bit_ready=0, busy=1, crc_valid=1.
  - crc_out and bit_count (=FRAME_BITS) frozen.
  - crc_ready=1 -> next edge: crc_valid=0, state=IDLE, bit_count=0. crc_out keeps its last value.
- start rules:
  - start in SHIFT or HOLD is ignored; it is not queued.
  - start on the same cycle HOLD exits is ignored. A new frame needs start asserted while in IDLE, so the minimum frame-to-frame gap is 1 IDLE cycle.
- bit_valid while bit_ready=0 is ignored; the bit is not consumed.
- Reset mid-frame or in HOLD:
  - The frame is aborted and the partial CRC discarded.
  - crc_valid drops on the next edge; no result is produced.
- All arithmetic is 8-bit modulo 2. bit_count never exceeds FRAME_BITS.
- Outputs are registered, except bit_ready and busy, which decode directly from state.

Test Plan:
- Byte 0x01, FRAME_BITS=8, defaults:
  - start, then 8 bits 0,0,0,0,0,0,0,1 with bit_valid held high.
  - Required: crc_out=8'h07, crc_valid rises the cycle after the 8th bit, bit_count=8.
- Bytes 0x80 and 0xFF:
  - 0x80 (bits 1,0,0,0,0,0,0,0) -> crc_out=8'h89.
  - Next frame 0xFF -> crc_out=8'hF3. Each frame is started with start in IDLE.
  - Required: crc_reg re-initialised to INIT per frame, so the two results are independent.
- FRAME_BITS=72, ASCII "123456789" MSB-first:
  - Required: crc_out=8'hF4.
  - Repeat with bit_valid toggled randomly: the same 8'hF4 results, and bit_count advances only on handshake cycles.
- Handshake and start rules:
  - Hold crc_ready=0 for 5 cycles in HOLD -> crc_valid stays 1, crc_out constant, bit_ready=0.
  - Pulse start during HOLD -> ignored.
  - crc_ready=1 together with start -> state IDLE, no new frame.
  - start next cycle -> frame begins.
- Reset mid-frame:
  - Assert rst after 4 of 8 bits -> next edge all outputs at reset values, crc_valid never asserts.
  - A subsequent full frame of 0x01 -> crc_out=8'h07.
- XOROUT and all-zero data:
  - XOROUT=8'hFF, data 0x00 -> crc_out=8'hFF.
  - XOROUT=8'h00, data 0x00 -> crc_out=8'h00.
